seq_pattern_tx: RTL and testbench
=================================

# seq_pattern_tx

Serial pattern transmitter. It accepts a parallel pattern word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a single-bit serial line. The pattern can be repeated a programmable number of times, with a one-cycle gap between repetitions. It is the stimulus source for the serial sequence-detector FSMs in this design, and its `out_o` connects directly to a detector's `in_i`.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits.
- `LEN_W`, default `$clog2(WIDTH+1)`: width of the length field.
- `REP_W`, default 4: width of the repeat field.
- `clk`, in, 1: rising-edge clock. This is the only clock.
- `reset_i`, in, 1: reset, asynchronous, active-low. Asserting it forces all state and outputs to reset values immediately.
- `data_i`, in, WIDTH: pattern. Only the low `len` bits are used.
- `len_i`, in, LEN_W: bits per repetition. Legal range is 1..WIDTH; 0 or any value above WIDTH is treated as WIDTH.
- `rep_i`, in, REP_W: extra repetitions. Total transmissions = `rep_i`+1.
- `valid_i`, in, 1: request. `data_i`, `len_i` and `rep_i` are sampled on the accept edge.
- `ready_o`, out, 1: `ready_o` = (state==IDLE) && !`abort_i`.
- `abort_i`, in, 1: synchronous abort.
- `out_o`, out, 1: serial bit, registered.
- `out_valid_o`, out, 1: `out_o` carries a pattern bit this cycle, registered.
- `busy_o`, out, 1: state != IDLE.
- `done_o`, out, 1: one-cycle pulse after the final bit of the final repetition.

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: emitting bits.
  - GAP: one idle cycle between repetitions.
  - DONE: completion pulse.
- Transitions:
  - IDLE: goes to SHIFT on accept (`valid_i` && `ready_o`). Holds while `valid_i`=0.
  - SHIFT: when the bit index reaches 0, goes to GAP if repetitions remain, else DONE.
  - GAP: goes to SHIFT. Reloads the bit index to `len`-1 from the captured length.
  - DONE: goes to IDLE unconditionally.
  - `abort_i`=1 in SHIFT, GAP or DONE: goes to IDLE on the next edge. `out_valid_o` clears, `done_o` is not asserted, the captured pattern is discarded.
  - `abort_i` in IDLE only gates `ready_o`.
- Bit order: bit `len`-1 of the captured data is sent first and bit 0 last. Bits above `len`-1 are never sent.
- Counters:
  - Bit index: LEN_W bits, counts down `len`-1 → 0.
  - Repeat count: REP_W bits, counts down from `rep_i` to 0.
  - Neither counter wraps; each reloads only on accept or in GAP.
- Outputs outside SHIFT: `out_o`=0 and `out_valid_o`=0 in IDLE, GAP and DONE.
- Request timing: `valid_i` held high through a transmission has no effect. A new request is accepted only when back in IDLE.
- Reset values: `out_o`=0, `out_valid_o`=0, `done_o`=0, `busy_o`=0, state=IDLE. `ready_o`=1 when `abort_i`=0.
- Reset mid-operation: the transmission is lost. No `done_o` is generated. After release, the block is idle.

## Timing
- Accept on edge T. The first bit appears on `out_o` and `out_valid_o` after edge T+1 and is valid during cycle T+1.
- For a single transmission of length L:
  - Bits occupy cycles T+1..T+L.
  - `done_o`=1 in cycle T+L+1.
  - `ready_o`=1 again in cycle T+L+2.
- For R = `rep_i`+1 transmissions, total busy cycles = R·L + (R−1) + 1.
- Back-to-back minimum request spacing is L+2 cycles for R=1.
- `abort_i` sampled high at edge E: `out_valid_o`=0 and `busy_o`=0 from E onward. `ready_o` is 1 in the cycle after `abort_i` falls.

## Structure
- Package `seq_pattern_pkg`:
  - `tx_state_t` enum logic [1:0]: IDLE, SHIFT, GAP, DONE.
  - Default `WIDTH`/`REP_W` localparams.
  - Function `eff_len(len, WIDTH)` that applies the 0/overflow → WIDTH rule.
- Sub-module `piso_shift_reg`: parallel-load, MSB-select shift register with index counter. The top level holds the FSM, the repeat counter and the output registers.

## Test plan
- Reset then idle:
  - During reset, all outputs hold reset values.
  - After release with `valid_i`=0 for 20 cycles: `ready_o`=1, `out_valid_o`=0 throughout.
- Single pattern: `data_i`=8'h0B, `len_i`=4, `rep_i`=0, accept at T.
  - `out_o`=1,0,1,1 with `out_valid_o`=1 in T+1..T+4.
  - `done_o`=1 only in T+5.
  - `ready_o`=1 at T+6.
  - A downstream "1011" detector asserts exactly once.
- Repeat with gap: `data_i`=8'h05, `len_i`=3, `rep_i`=2.
  - Stream 101,gap,101,gap,101.
  - `out_valid_o` low exactly in the two gap cycles.
  - `done_o` at T+12.
- Length edge cases:
  - `len_i`=0 and `len_i`=15 with `data_i`=8'hA5 both emit 1,0,1,0,0,1,0,1.
  - `len_i`=1 emits only bit 0.
- Abort: assert `abort_i` in the 3rd bit cycle of an 8-bit send.
  - `out_valid_o`=0 from the next cycle.
  - No `done_o`.
  - `ready_o` returns after `abort_i` falls.
- Reset mid-transfer: drop `reset_i` during the 2nd repetition.
  - Outputs clear asynchronously.
  - After release, a new 4-bit request is transmitted correctly from its first bit.

Source files
------------

// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg: shared state type, default sizes and length normalisation
package seq_pattern_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} tx_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_REP_W = 4;

    // A zero or oversized length means "send the whole word"
    function automatic int eff_len(input int len, input int width);
        return (len == 0 || len > width) ? width : len;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: holds the captured pattern and walks a bit index from len-1 down to 0.
// bit_d_o is the bit selected by the next-state index, so the caller can register it in step with the FSM.
module piso_shift_reg
    import seq_pattern_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             reload_i,
    input  logic             shift_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [LEN_W-1:0] idx_o,
    output logic             bit_d_o
);

    logic [WIDTH-1:0] data_q, data_d, sel;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            data_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        data_d = load_i ? data_i : clear_i ? '0 : data_q;
        len_d  = load_i ? len_i  : clear_i ? '0 : len_q;
        idx_d  = load_i                      ? len_i - LEN_W'(1) :
                 reload_i                    ? len_q - LEN_W'(1) :
                 (shift_i && idx_q != '0)    ? idx_q - LEN_W'(1) :
                 clear_i                     ? '0 : idx_q;
    end

    assign sel     = data_d >> idx_d;
    assign bit_d_o = sel[0];
    assign idx_o   = idx_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: accepts a pattern word and shifts it out MSB-first, repeated rep_i+1 times
// with a one-cycle gap between repetitions and a done pulse after the last bit.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = $clog2(WIDTH + 1),
    parameter int REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [REP_W-1:0] rep_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             abort_i,
    output logic             out_o,
    output logic             out_valid_o,
    output logic             busy_o,
    output logic             done_o
);

    tx_state_t        state_q, state_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [LEN_W-1:0] idx;
    logic             out_q, out_d, out_valid_q, out_valid_d, done_q, done_d;
    logic             accept, kill, bit_d;

    assign ready_o = (state_q == IDLE) && !abort_i;
    assign busy_o  = state_q != IDLE;
    assign accept  = valid_i && ready_o;
    assign kill    = abort_i && state_q != IDLE;

    piso_shift_reg #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_piso (
        .clk      (clk),
        .reset_i  (reset_i),
        .load_i   (accept),
        .reload_i (state_q == GAP && !abort_i),
        .shift_i  (state_q == SHIFT && !abort_i),
        .clear_i  (kill),
        .data_i   (data_i),
        .len_i    (LEN_W'(eff_len(int'(len_i), WIDTH))),
        .idx_o    (idx),
        .bit_d_o  (bit_d)
    );

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            rep_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_q       <= rep_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rep_d   = accept ? rep_i : kill ? '0 : (state_q == GAP) ? rep_q - REP_W'(1) : rep_q;
        if (kill)
            state_d = IDLE;
        else
            unique case (state_q)
                IDLE:    state_d = accept ? SHIFT : IDLE;
                SHIFT:   state_d = (idx != '0) ? SHIFT : (rep_q != '0) ? GAP : DONE;
                GAP:     state_d = SHIFT;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        out_valid_d = state_d == SHIFT;
        out_d       = (state_d == SHIFT) && bit_d;
        done_d      = state_d == DONE;
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed vectors for the serial pattern transmitter; expected
// streams are written out by hand as strings ('-' marks a gap cycle).
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [7:0] data_i = '0;
    logic [3:0] len_i = '0;
    logic [3:0] rep_i = '0;
    logic       valid_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       ready_o, out_o, out_valid_o, busy_o, done_o;
    int         n_checks = 0;
    int         n_fail = 0;
    int         hits;

    always #5 clk = ~clk;

    seq_pattern_tx dut (
        .clk         (clk),
        .reset_i     (reset_i),
        .data_i      (data_i),
        .len_i       (len_i),
        .rep_i       (rep_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .abort_i     (abort_i),
        .out_o       (out_o),
        .out_valid_o (out_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out"},   32'(out_o), 0);
        check({tag, "_valid"}, 32'(out_valid_o), 0);
        check({tag, "_done"},  32'(done_o), 0);
        check({tag, "_busy"},  32'(busy_o), 0);
    endtask

    // Sends one request and checks every cycle of the stream, the done pulse and the return of ready.
    task automatic xfer(input string tag, input logic [7:0] d, input logic [3:0] l,
                        input logic [3:0] r, input string s, input bit hold, output int det);
        logic [3:0] hist = '0;
        det = 0;
        @(negedge clk);
        check({tag, "_ready_pre"}, 32'(ready_o), 1);
        data_i = d; len_i = l; rep_i = r; valid_i = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= s.len(); k++) begin
            @(negedge clk);
            if (!hold) valid_i = 1'b0;
            check($sformatf("%s_valid%0d", tag, k), 32'(out_valid_o), 32'(s[k-1] != "-"));
            check($sformatf("%s_bit%0d", tag, k),   32'(out_o),       32'(s[k-1] == "1"));
            check($sformatf("%s_done%0d", tag, k),  32'(done_o), 0);
            check($sformatf("%s_busy%0d", tag, k),  32'(busy_o), 1);
            if (out_valid_o) begin
                hist = {hist[2:0], out_o};
                if (hist == 4'b1011) det++;
            end
        end
        @(negedge clk);
        check({tag, "_done"},       32'(done_o), 1);
        check({tag, "_done_valid"}, 32'(out_valid_o), 0);
        check({tag, "_done_busy"},  32'(busy_o), 1);
        check({tag, "_done_ready"}, 32'(ready_o), 0);
        @(negedge clk);
        valid_i = 1'b0;
        check({tag, "_post_done"},  32'(done_o), 0);
        check({tag, "_post_ready"}, 32'(ready_o), 1);
        check({tag, "_post_busy"},  32'(busy_o), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        check("rst_ready", 32'(ready_o), 1);
        reset_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle_ready%0d", i), 32'(ready_o), 1);
            check($sformatf("idle_valid%0d", i), 32'(out_valid_o), 0);
        end

        xfer("single", 8'h0B, 4'd4, 4'd0, "1011", 1'b0, hits);
        check("single_detect", 32'(hits), 1);
        xfer("repeat", 8'h05, 4'd3, 4'd2, "101-101-101", 1'b1, hits);
        xfer("len0",   8'hA5, 4'd0, 4'd0, "10100101", 1'b0, hits);
        xfer("len15",  8'hA5, 4'd15, 4'd0, "10100101", 1'b0, hits);
        xfer("len1a",  8'hFE, 4'd1, 4'd0, "0", 1'b0, hits);
        xfer("len1b",  8'h01, 4'd1, 4'd0, "1", 1'b0, hits);

        // Abort during the third bit of an 8-bit send
        @(negedge clk);
        data_i = 8'hFF; len_i = 4'd8; rep_i = 4'd0; valid_i = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            valid_i = 1'b0;
            check($sformatf("abort_pre%0d", k), 32'(out_valid_o), 1);
        end
        abort_i = 1'b1;
        @(negedge clk);
        check("abort_valid", 32'(out_valid_o), 0);
        check("abort_busy",  32'(busy_o), 0);
        check("abort_ready", 32'(ready_o), 0);
        abort_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("abort_nodone%0d", k), 32'(done_o), 0);
            check($sformatf("abort_rdy%0d", k),    32'(ready_o), 1);
        end

        // Reset during the second repetition, then a fresh 4-bit request
        @(negedge clk);
        data_i = 8'h05; len_i = 4'd3; rep_i = 4'd2; valid_i = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        valid_i = 1'b0;
        check("mid_valid_pre", 32'(out_valid_o), 1);
        #2 reset_i = 1'b0;
        #1 check_idle_outputs("mid_rst");
        @(negedge clk);
        reset_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("mid_nodone%0d", k), 32'(done_o), 0);
            check($sformatf("mid_rdy%0d", k),    32'(ready_o), 1);
        end
        xfer("after_rst", 8'h06, 4'd4, 4'd0, "0110", 1'b0, hits);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
